// File: rtl/pump_fill_ctrl_if.sv
// Sensor, operator-enable and status bundle of the pump fill controller.
// The controller sits on the slave side. The plant or operator panel sits on the master side.
interface pump_fill_ctrl_if;
  logic       high;
  logic       low;
  logic       p;
  logic       pump_on;
  logic [7:0] count;
  logic       fault;
  logic [1:0] state;

  modport master (output high, low, p, input pump_on, count, fault, state);
  modport slave  (input high, low, p, output pump_on, count, fault, state);
endinterface

// File: rtl/pump_fill_ctrl.sv
// Pump fill controller. It synchronizes and debounces the tank sensors and the operator
// enable, runs the fill state machine, counts completed fills and latches faults.
module pump_fill_ctrl #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned FILL_TIMEOUT = 200
) (
  input logic             clk,
  input logic             rst_n,
  pump_fill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_FULL  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE - 1);
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [15:0] TO_LAST   = 16'(FILL_TIMEOUT - 1);

  // Bit order is {p, low, high} throughout the conditioning logic.
  logic [2:0]  w_raw;
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_deb;
  logic [15:0] r_db_cnt [3];

  assign w_raw = {bus.p, bus.low, bus.high};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values; the second sync stage depends on that.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  logic w_h;
  logic w_l;
  logic w_p;
  logic w_conflict;
  logic w_tick_wrap;
  logic w_timeout;

  assign w_h         = r_deb[0];
  assign w_l         = r_deb[1];
  assign w_p         = r_deb[2];
  assign w_conflict  = w_h & ~w_l;

  state_t      r_state;
  logic        r_pump_on;
  logic        r_fault;
  logic [7:0]  r_count;
  logic [23:0] r_tick;
  logic [15:0] r_to_cnt;

  // The timeout fires on the edge where the tick counter would reach FILL_TIMEOUT.
  // That edge falls exactly FILL_TIMEOUT*TICK_DIV cycles after FILL entry.
  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_timeout   = w_tick_wrap && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pump_on <= 1'b0;
      r_fault   <= 1'b0;
      r_count   <= '0;
      r_tick    <= '0;
      r_to_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_conflict) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else if (w_p && !w_l) begin
            r_state   <= S_FILL;
            r_pump_on <= 1'b1;
            r_tick    <= '0;
            r_to_cnt  <= '0;
          end
        end
        S_FILL: begin
          if (w_tick_wrap) begin
            r_tick   <= '0;
            r_to_cnt <= r_to_cnt + 16'd1;
          end else begin
            r_tick <= r_tick + 24'd1;
          end
          if (w_conflict) begin
            r_state   <= S_FAULT;
            r_pump_on <= 1'b0;
            r_fault   <= 1'b1;
          end else if (!w_p) begin
            r_state   <= S_IDLE;
            r_pump_on <= 1'b0;
          end else if (w_h) begin
            r_state   <= S_FULL;
            r_pump_on <= 1'b0;
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
          end else if (w_timeout) begin
            r_state   <= S_FAULT;
            r_pump_on <= 1'b0;
            r_fault   <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_conflict) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else if (!w_l) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (!w_p) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pump_on = r_pump_on;
  assign bus.fault   = r_fault;
  assign bus.count   = r_count;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_pump_fill_ctrl.sv
// Directed bench for pump_fill_ctrl with DEBOUNCE=4, TICK_DIV=10 and FILL_TIMEOUT=5.
// Inputs change 1 ns after a rising edge, so a debounced value lands 6 edges later and the state moves on the 7th.
module tb_pump_fill_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pump_fill_ctrl_if bus ();

  pump_fill_ctrl #(
    .DEBOUNCE    (4),
    .TICK_DIV    (10),
    .FILL_TIMEOUT(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       high;
    logic       low;
    logic       p;
    int         cycles;
    logic [1:0] st;
    logic       pump;
    logic       flt;
    int         cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] st, input logic pump,
                           input logic flt, input int cnt);
    check({name, " state"}, 32'(bus.state), 32'(st));
    check({name, " pump_on"}, 32'(bus.pump_on), 32'(pump));
    check({name, " fault"}, 32'(bus.fault), 32'(flt));
    check({name, " count"}, 32'(bus.count), 32'(cnt));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic l, input logic pe);
    bus.high = h;
    bus.low  = l;
    bus.p    = pe;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_out("async reset", IDLE, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to FULL, then run to a timeout and clear the resulting fault.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2,  IDLE,  1'b0, 1'b0, 0, "idle after reset"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6,  IDLE,  1'b0, 1'b0, 0, "p debouncing"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1,  FILL,  1'b1, 1'b0, 0, "enter fill"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 6,  FILL,  1'b1, 1'b0, 0, "high debouncing"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1,  FULL,  1'b0, 1'b0, 1, "enter full"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 7,  FULL,  1'b0, 1'b0, 1, "p ignored in full"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 7,  IDLE,  1'b0, 1'b0, 1, "full to idle"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 7,  FILL,  1'b1, 1'b0, 1, "refill for timeout"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 49, FILL,  1'b1, 1'b0, 1, "one before timeout"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1,  FAULT, 1'b0, 1'b1, 1, "timeout fault"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6,  FAULT, 1'b0, 1'b1, 1, "fault held"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1,  IDLE,  1'b0, 1'b0, 1, "fault cleared"});

    foreach (vecs[i]) begin
      drive(vecs[i].high, vecs[i].low, vecs[i].p);
      step(vecs[i].cycles);
      check_out(vecs[i].name, vecs[i].st, vecs[i].pump, vecs[i].flt, vecs[i].cnt);
    end

    // FULL -> IDLE -> FILL on consecutive edges while p stays high.
    drive(1'b0, 1'b0, 1'b1); step(7);
    check_out("refill", FILL, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1'b1); step(7);
    check_out("second full", FULL, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b1); step(6);
    check_out("full before drain", FULL, 1'b0, 1'b0, 2);
    step(1);
    check_out("drain to idle", IDLE, 1'b0, 1'b0, 2);
    step(1);
    check_out("idle to fill", FILL, 1'b1, 1'b0, 2);

    // Three-cycle glitches fall one short of the debounce window.
    drive(1'b1, 1'b0, 1'b1); step(3);
    drive(1'b0, 1'b0, 1'b1); step(10);
    check_out("high glitch", FILL, 1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0); step(3);
    drive(1'b0, 1'b0, 1'b1); step(10);
    check_out("p glitch", FILL, 1'b1, 1'b0, 2);

    // Conflict in FILL goes to FAULT without counting a fill.
    drive(1'b1, 1'b0, 1'b1); step(6);
    check_out("fill conflict pending", FILL, 1'b1, 1'b0, 2);
    step(1);
    check_out("fill conflict", FAULT, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 1'b0); step(6);
    check_out("fault hold until p", FAULT, 1'b0, 1'b1, 2);
    step(1);
    check_out("clear fill conflict", IDLE, 1'b0, 1'b0, 2);

    // Conflict in FULL.
    drive(1'b0, 1'b0, 1'b1); step(7);
    check_out("fill again", FILL, 1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b1); step(7);
    check_out("third full", FULL, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 1'b1); step(6);
    check_out("full conflict pending", FULL, 1'b0, 1'b0, 3);
    step(1);
    check_out("full conflict", FAULT, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b0); step(7);
    check_out("clear full conflict", IDLE, 1'b0, 1'b0, 3);

    // Reach count=7 and pulse reset between clock edges in FILL.
    drive(1'b0, 1'b0, 1'b1); step(7);
    for (int i = 4; i <= 7; i++) begin
      drive(1'b1, 1'b1, 1'b1); step(7);
      check("fill to 7 count", 32'(bus.count), 32'(i));
      drive(1'b0, 1'b0, 1'b1); step(8);
    end
    check_out("before reset", FILL, 1'b1, 1'b0, 7);
    step(3);
    #2 rst_n = 1'b0;
    #1 check_out("mid-fill reset", IDLE, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);
    check_out("after reset release", IDLE, 1'b0, 1'b0, 0);

    // 257 fills; count saturates at 255.
    drive(1'b0, 1'b0, 1'b1); step(7);
    check_out("saturation start", FILL, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 1'b1, 1'b1); step(7);
      check("sat full state", 32'(bus.state), 32'(FULL));
      check("sat count", 32'(bus.count), 32'((i > 255) ? 255 : i));
      drive(1'b0, 1'b0, 1'b1); step(8);
      check("sat refill state", 32'(bus.state), 32'(FILL));
    end
    check_out("saturated", FILL, 1'b1, 1'b0, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
